// File: rtl/mcu_spi_link_pkg.sv
// Shared constants for the MCU link: target IDs and HID command codes.
// No logic; the helper below is a saturating byte counter increment.
package mcu_link_pkg;

    localparam logic [7:0] TGT_HID  = 8'h01;
    localparam logic [7:0] TGT_LOOP = 8'hFF;

    localparam logic [7:0] CMD_STATUS  = 8'd0;
    localparam logic [7:0] CMD_KBD     = 8'd1;
    localparam logic [7:0] CMD_MOUSE   = 8'd2;
    localparam logic [7:0] CMD_JOY_IN  = 8'd3;
    localparam logic [7:0] CMD_JOY_OUT = 8'd4;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mcu_spi_link_sync_edge.sv
// Purpose: 2-FF synchronizer for an async pin plus registered rise/fall pulses.
// Latency: pulses appear 3 clk edges after the pin changes.
// Backpressure: none; pins are free-running.
module sync_edge #(
    parameter logic IDLE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= IDLE;
            s2   <= IDLE;
            s3   <= IDLE;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
            fall <= ~s2 & s3;
        end
    end

    assign sync = s2;

endmodule

// File: rtl/mcu_spi_link.sv
// Purpose: mode-0 SPI slave deframing target+payload bytes to the HID handler; MCU_SPI_LOOPBACK_EN adds target 8'hFF echo.
// Latency: pin SCLK rise to data_in_strobe is 4 clk edges; MISO returns the response one byte behind.
// Backpressure: none; the MCU must keep SCLK half-period >= MIN_HALF clk cycles.
module mcu_spi_link
    import mcu_link_pkg::*;
#(
    parameter logic [7:0] TARGET_HID = TGT_HID,
    parameter int         MIN_HALF   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_cs_n,
    input  logic       spi_sclk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       data_in_strobe,
    output logic       data_in_start,
    output logic [7:0] data_in,
    input  logic [7:0] data_out,
    output logic       frame_active,
    output logic [7:0] byte_count
);

    logic       cs_lvl, cs_rise, cs_fall;
    logic       sclk_lvl, sclk_rise, sclk_fall;
    logic       mosi_s1, mosi_s2;
    logic [1:0] settle;
    logic       armed, active;
    logic [7:0] target, rx_shift, tx_shift, next_tx, rx_byte;
    logic [2:0] bit_cnt;
    logic [7:0] half_cnt;
    logic       is_hid;
`ifdef MCU_SPI_LOOPBACK_EN
    logic [7:0] loop_byte;
`endif

    sync_edge #(.IDLE(1'b1)) u_cs (
        .clk(clk), .reset(reset), .din(spi_cs_n),
        .sync(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.IDLE(1'b0)) u_sclk (
        .clk(clk), .reset(reset), .din(spi_sclk),
        .sync(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    assign rx_byte = {rx_shift[6:0], mosi_s2};
    assign is_hid  = (target == TARGET_HID);

    always_comb begin
        next_tx = 8'h00;
        if (is_hid) begin
            next_tx = data_out;
        end
`ifdef MCU_SPI_LOOPBACK_EN
        else if (target == TGT_LOOP) begin
            next_tx = loop_byte;
        end
`endif
    end

    // A frame is only accepted once cs_n has been seen high after reset, so a
    // reset that lands mid-frame ignores the rest of that frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mosi_s1        <= 1'b0;
            mosi_s2        <= 1'b0;
            settle         <= 2'd0;
            armed          <= 1'b0;
            active         <= 1'b0;
            target         <= 8'h00;
            rx_shift       <= 8'h00;
            tx_shift       <= 8'h00;
            bit_cnt        <= 3'd0;
            byte_count     <= 8'h00;
            data_in_strobe <= 1'b0;
            data_in_start  <= 1'b0;
            data_in        <= 8'h00;
`ifdef MCU_SPI_LOOPBACK_EN
            loop_byte      <= 8'h00;
`endif
        end else begin
            mosi_s1        <= spi_mosi;
            mosi_s2        <= mosi_s1;
            data_in_strobe <= 1'b0;
            data_in_start  <= 1'b0;
            if (settle != 2'd3) begin
                settle <= settle + 2'd1;
            end else if (cs_lvl) begin
                armed <= 1'b1;
            end

            if (cs_rise) begin
                active  <= 1'b0;
                target  <= 8'h00;
                bit_cnt <= 3'd0;
            end else if (cs_fall && armed) begin
                active     <= 1'b1;
                bit_cnt    <= 3'd0;
                byte_count <= 8'h00;
                target     <= 8'h00;
                rx_shift   <= 8'h00;
                tx_shift   <= 8'h00;
`ifdef MCU_SPI_LOOPBACK_EN
                loop_byte  <= 8'h00;
`endif
            end else if (active) begin
                if (sclk_rise) begin
                    rx_shift <= rx_byte;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_count <= sat_inc(byte_count);
                        if (byte_count == 8'd0) begin
                            target <= rx_byte;
                        end else begin
`ifdef MCU_SPI_LOOPBACK_EN
                            loop_byte <= rx_byte;
`endif
                            if (is_hid) begin
                                data_in_strobe <= 1'b1;
                                data_in_start  <= (byte_count == 8'd1);
                                data_in        <= rx_byte;
                            end
                        end
                    end
                end
                if (sclk_fall) begin
                    if (bit_cnt == 3'd0) begin
                        tx_shift <= next_tx;
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            half_cnt <= 8'h00;
        end else if (sclk_rise || sclk_fall) begin
            half_cnt <= 8'h00;
        end else if (half_cnt != 8'hFF) begin
            half_cnt <= half_cnt + 8'd1;
        end
    end

    assign spi_miso     = active & tx_shift[7];
    assign spi_miso_oe  = active;
    assign frame_active = active;

    // The first edge of a frame has no preceding edge to measure from.
    a_min_half: assert property (@(posedge clk) disable iff (reset)
        (active && (sclk_rise || sclk_fall) && (bit_cnt != 3'd0 || byte_count != 8'd0))
            |-> (half_cnt >= 8'(MIN_HALF - 1)));

    a_mode0_idle: assert property (@(posedge clk) disable iff (reset)
        (cs_fall && armed && !active) |-> !sclk_lvl);

endmodule

// File: tb/tb_mcu_spi_link.sv
// Bench for mcu_spi_link: directed and random SPI frames against a byte-level model
// of expected strobes, MISO bytes and byte counts.
module tb_mcu_spi_link;

    logic       clk = 1'b0;
    logic       reset, spi_cs_n, spi_sclk, spi_mosi;
    logic       spi_miso, spi_miso_oe, data_in_strobe, data_in_start, frame_active;
    logic [7:0] data_in, data_out, byte_count;

    always #5 clk = ~clk;

    mcu_spi_link dut (
        .clk(clk), .reset(reset), .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .data_in_strobe(data_in_strobe), .data_in_start(data_in_start),
        .data_in(data_in), .data_out(data_out), .frame_active(frame_active),
        .byte_count(byte_count)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int strobe_cnt = 0;
    int resp_idx = 0;
    logic prev_strobe = 1'b0;

    logic [8:0] exp_q[$];
    logic [7:0] fr[16];
    int         fr_len;
    logic [7:0] resp[16];
    logic [7:0] miso_got[16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Per-cycle compare process: strobes against the expected queue, idle pins.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!reset) begin
            if (!frame_active) begin
                check("idle_miso_oe", {spi_miso, spi_miso_oe}, 0);
                check("idle_no_strobe", data_in_strobe, 0);
            end else begin
                check("active_oe", spi_miso_oe, 1);
            end
            if (data_in_strobe) begin
                strobe_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_strobe: got data %0h start %0b, required no strobe", data_in, data_in_start);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_data", data_in, e[7:0]);
                    check("strobe_start", data_in_start, e[8]);
                end
                check("strobe_latency", cyc - last_rise_cyc, 4);
                check("strobe_width", prev_strobe, 0);
                if (resp_idx < 16) data_out = resp[resp_idx];
                resp_idx++;
            end
        end
        prev_strobe = data_in_strobe;
    end

    function automatic logic [7:0] miso_model(input int j);
        if (j < 2) return 8'h00;
        if (fr[0] == 8'h01) return resp[j-2];
`ifdef MCU_SPI_LOOPBACK_EN
        if (fr[0] == 8'hFF) return fr[j-1];
`endif
        return 8'h00;
    endfunction

    task automatic sclk_bit(input int half, input logic b, output logic m, input bit end_cs);
        spi_mosi = b;
        repeat (half) @(negedge clk);
        spi_sclk = 1'b1;
        m = spi_miso;
        last_rise_cyc = cyc;
        if (end_cs) spi_cs_n = 1'b1;
        repeat (half) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic run_frame(input int half, input int tail_bits, input bit cs_on_last);
        logic [7:0] got;
        logic       m;
        int         done;
        done = cs_on_last ? fr_len - 1 : fr_len;
        for (int j = 1; j < done; j++)
            if (fr[0] == 8'h01) exp_q.push_back({(j == 1), fr[j]});
        resp_idx   = 0;
        strobe_cnt = 0;
        data_out   = 8'h00;
        spi_cs_n   = 1'b0;
        repeat (half) @(negedge clk);
        check("frame_active_start", frame_active, 1);
        for (int j = 0; j < fr_len; j++) begin
            got = 8'h00;
            for (int b = 7; b >= 0; b--) begin
                sclk_bit(half, fr[j][b], m, cs_on_last && (j == fr_len - 1) && (b == 0));
                got = {got[6:0], m};
            end
            miso_got[j] = got;
            check("miso_byte", got, miso_model(j));
        end
        for (int b = 0; b < tail_bits; b++) sclk_bit(half, 1'($urandom), m, 1'b0);
        repeat (half) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (half) @(negedge clk);
        check("frame_active_end", frame_active, 0);
        check("byte_count", byte_count, done);
        check("strobes_pending", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic load(input int n, input logic [63:0] bytes);
        fr_len = n;
        for (int i = 0; i < n; i++) fr[i] = bytes[8*(n-1-i) +: 8];
    endtask

    initial begin
        logic m;
        reset = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; data_out = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_miso", spi_miso, 0);
        check("rst_miso_oe", spi_miso_oe, 0);
        check("rst_strobe", data_in_strobe, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_start", data_in_start, 0);
        check("rst_data_in", data_in, 8'h00);
        check("rst_frame_active", frame_active, 0);
        check("rst_byte_count", byte_count, 8'h00);

        // HID frame with random responses
        load(5, 64'h01_02_05_FB_03);
        for (int i = 0; i < 16; i++) resp[i] = 8'($urandom);
        run_frame(8, 0, 1'b0);
        check("t1_strobes", strobe_cnt, 4);
        check("t1_miso0", miso_got[0], 8'h00);
        check("t1_miso1", miso_got[1], 8'h00);

        // Pinned response stream
        load(4, 64'h01_00_00_00);
        resp[0] = 8'h5C; resp[1] = 8'h42; resp[2] = 8'h99;
        run_frame(8, 0, 1'b0);
        check("t2_miso2", miso_got[2], 8'h5C);
        check("t2_miso3", miso_got[3], 8'h42);

        // Non-HID target
        load(3, 64'h07_01_AA);
        run_frame(9, 0, 1'b0);
        check("t3_strobes", strobe_cnt, 0);
        check("t3_byte_count", byte_count, 8'd3);
        check("t3_miso2", miso_got[2], 8'h00);

        // Partial trailing byte dropped
        load(2, 64'h01_04);
        run_frame(8, 5, 1'b0);
        check("t4_strobes", strobe_cnt, 1);
        check("t4_byte_count", byte_count, 8'd2);

        // cs_n rises together with the completing SCLK edge
        load(3, 64'h01_04_77);
        run_frame(8, 0, 1'b1);
        check("t5_strobes", strobe_cnt, 1);

        // Loopback target
        load(4, 64'hFF_12_34_56);
        run_frame(8, 0, 1'b0);
        check("t6_strobes", strobe_cnt, 0);
`ifdef MCU_SPI_LOOPBACK_EN
        check("t6_miso2", miso_got[2], 8'h12);
        check("t6_miso3", miso_got[3], 8'h34);
`else
        check("t6_miso2", miso_got[2], 8'h00);
        check("t6_miso3", miso_got[3], 8'h00);
`endif

        // Reset mid-byte inside an HID frame
        strobe_cnt = 0;
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 7; b >= 0; b--) sclk_bit(8, 1'(b == 0), m, 1'b0);
        for (int b = 0; b < 3; b++) sclk_bit(8, 1'b1, m, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_miso_oe", spi_miso_oe, 0);
        check("mid_rst_frame_active", frame_active, 0);
        check("mid_rst_miso", spi_miso, 0);
        check("mid_rst_byte_count", byte_count, 8'h00);
        check("mid_rst_strobe", data_in_strobe, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int b = 0; b < 13; b++) sclk_bit(8, 1'($urandom), m, 1'b0);
        check("post_rst_frame_active", frame_active, 0);
        check("post_rst_strobes", strobe_cnt, 0);
        spi_cs_n = 1'b1;
        repeat (16) @(negedge clk);

        // Random frames
        for (int it = 0; it < 12; it++) begin
            int  half, tail;
            bit  csl;
            half   = $urandom_range(8, 12);
            fr_len = $urandom_range(1, 8);
            case ($urandom_range(0, 3))
                0, 1:    fr[0] = 8'h01;
                2:       fr[0] = 8'hFF;
                default: fr[0] = 8'($urandom);
            endcase
            for (int i = 1; i < fr_len; i++) fr[i] = 8'($urandom);
            for (int i = 0; i < 16; i++) resp[i] = 8'($urandom);
            csl  = ($urandom_range(0, 3) == 0);
            tail = csl ? 0 : $urandom_range(0, 7);
            run_frame(half, tail, csl);
        end

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
